// File: rtl/display_scan_ctrl.sv
`timescale 1ns/1ps
// Purpose : scan controller and load scheduler for a 4-digit multiplexed 7-seg display.
// Latency : display_out is registered, one cycle behind sel/active/dir/blank_lz; loads commit at frame boundaries.
// Backpr. : load_ready = !pending_valid; a second load stalls until the pending value commits.
//
// Ports:
//    CLK, RST_N   clock (rising edge) and asynchronous active-low reset
//    enable       1 = scan, 0 = dark (counters held at zero, pending still commits)
//    dir          0 = slot k drives anode bit 3-k, 1 = slot k drives anode bit k
//    blank_lz     1 = blank leading zero digits (slot 3 always shown)
//    load_valid / load_ready / load_data   16-bit hex value handshake, [15:12] most significant
//    frame_done   one-cycle pulse after each frame boundary
//    display_out  {anode[3:0], seg[6:0]}, all active-low, seg a..g = [6]..[0]

module display_scan_ctrl #(
   parameter int T1MS = 50000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        enable,
   input  logic        dir,
   input  logic        blank_lz,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   output logic        frame_done,
   output logic [10:0] display_out
);

   localparam int             CW      = (T1MS > 1) ? $clog2(T1MS) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(T1MS - 1);
   localparam logic [10:0]    DARK_W  = 11'h7FF;

   // slot timer and digit select
   logic [CW-1:0] count;
   logic [1:0]    sel;

   // double buffer: active is what is shown, pending waits for a frame boundary
   logic [15:0]   active;
   logic [15:0]   pending;
   logic          pending_valid;

   logic          tick;
   logic          boundary;
   logic          xfer;

   logic [3:0]    nibble;
   logic          lz_blank;
   logic [1:0]    an_idx;
   logic [3:0]    anode_n;
   logic [6:0]    seg_n;
   logic [10:0]   disp_next;

   // ------------------------------------------------------------------
   // Hex to active-low segment pattern, bit 6 = a ... bit 0 = g
   // ------------------------------------------------------------------
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign tick       = (count == CNT_MAX);
   assign boundary   = tick && (sel == 2'd3);
   assign load_ready = !pending_valid;
   // A load can only land while nothing is pending, so it never races a commit.
   assign xfer       = load_valid && !pending_valid;

   // ------------------------------------------------------------------
   // Next display word from the current slot
   // ------------------------------------------------------------------
   always_comb begin
      nibble   = 4'h0;
      lz_blank = 1'b0;
      case (sel)
         2'd0: begin
            nibble   = active[15:12];
            lz_blank = (active[15:12] == 4'h0);
         end
         2'd1: begin
            nibble   = active[11:8];
            lz_blank = (active[15:8] == 8'h00);
         end
         2'd2: begin
            nibble   = active[7:4];
            lz_blank = (active[15:4] == 12'h000);
         end
         default: begin
            // least significant digit is always lit so zero reads "0"
            nibble   = active[3:0];
            lz_blank = 1'b0;
         end
      endcase
   end

   always_comb begin
      an_idx    = dir ? sel : (2'd3 - sel);
      anode_n   = ~(4'b0001 << an_idx);
      seg_n     = hex_to_seg(nibble);
      disp_next = (blank_lz && lz_blank) ? DARK_W : {anode_n, seg_n};
   end

   // ------------------------------------------------------------------
   // Scan state, double buffer and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count         <= '0;
         sel           <= 2'd0;
         active        <= 16'h0000;
         pending       <= 16'h0000;
         pending_valid <= 1'b0;
         frame_done    <= 1'b0;
         display_out   <= DARK_W;
      end else begin
         if (enable) begin
            if (tick) begin
               count <= '0;
               sel   <= sel + 2'd1;
            end else begin
               count <= count + 1'b1;
            end
            frame_done  <= boundary;
            display_out <= disp_next;
         end else begin
            // dark: hold the scan at the start of a frame so re-enable shows slot 0 first
            count       <= '0;
            sel         <= 2'd0;
            frame_done  <= 1'b0;
            display_out <= DARK_W;
         end

         // Commit at a frame boundary, or at once while dark since nothing is visible.
         if (pending_valid && (!enable || boundary)) begin
            active        <= pending;
            pending_valid <= 1'b0;
         end else if (xfer) begin
            pending       <= load_data;
            pending_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps

module tb_display_scan_ctrl;

   localparam int T = 4;

   logic        CLK        = 1'b0;
   logic        RST_N      = 1'b0;
   logic        enable     = 1'b0;
   logic        dir        = 1'b0;
   logic        blank_lz   = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data  = 16'h0000;
   logic        load_ready;
   logic        frame_done;
   logic [10:0] display_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] sb_q[$];

   typedef struct packed {
      logic [15:0]       value;
      logic              dir;
      logic              blz;
      logic [0:3][10:0]  exp;
   } vec_t;

   vec_t vecs[10];

   display_scan_ctrl #(.T1MS(T)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .enable      (enable),
      .dir         (dir),
      .blank_lz    (blank_lz),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .frame_done  (frame_done),
      .display_out (display_out)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic [15:0] value, input logic d, input logic b,
                               input logic [10:0] e0, input logic [10:0] e1,
                               input logic [10:0] e2, input logic [10:0] e3);
      vec_t v;
      v.value  = value;
      v.dir    = d;
      v.blz    = b;
      v.exp[0] = e0;
      v.exp[1] = e1;
      v.exp[2] = e2;
      v.exp[3] = e3;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [10:0] w, input int n);
      repeat (n) sb_q.push_back(w);
   endtask

   task automatic push_frame(input vec_t v);
      for (int s = 0; s < 4; s++) push_word(v.exp[s], T);
   endtask

   // one cycle: sample away from the active edge and compare against the scoreboard
   task automatic sb_step(input string name, input logic fd_exp);
      logic [10:0] w;
      @(negedge CLK);
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got display %0h", name, display_out);
      end else begin
         w = sb_q.pop_front();
         chk(name, 16'(display_out), 16'(w));
      end
      chk({name, "_fd"}, 16'(frame_done), 16'(fd_exp));
   endtask

   task automatic wait_ready(input string name);
      int k;
      k = 0;
      while (!load_ready && k < 64) begin
         @(negedge CLK);
         k++;
      end
      if (!load_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: load_ready timeout, got 0, expected 1", name);
      end
   endtask

   // load a vector, wait for it to commit, then check one whole frame
   task automatic run_vec(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("vec%0d", idx);
      @(negedge CLK);
      dir      = v.dir;
      blank_lz = v.blz;
      wait_ready({nm, "_pre"});
      load_valid = 1'b1;
      load_data  = v.value;
      push_frame(v);
      @(posedge CLK);
      #1;
      load_valid = 1'b0;
      load_data  = 16'($urandom);
      @(negedge CLK);
      chk({nm, "_ready_low"}, 16'(load_ready), 16'd0);
      wait_ready({nm, "_commit"});
      chk({nm, "_fd_commit"}, 16'(frame_done), 16'd1);
      for (int i = 0; i < 4 * T; i++)
         sb_step($sformatf("%s_c%0d", nm, i), (i == 4 * T - 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(16'h1234, 1'b0, 1'b0, 11'b0111_1001111, 11'b1011_0010010, 11'b1101_0000110, 11'b1110_1001100);
      vecs[1] = mk(16'h1234, 1'b1, 1'b0, 11'b1110_1001111, 11'b1101_0010010, 11'b1011_0000110, 11'b0111_1001100);
      vecs[2] = mk(16'h0050, 1'b0, 1'b1, 11'h7FF,          11'h7FF,          11'b1101_0100100, 11'b1110_0000001);
      vecs[3] = mk(16'h0000, 1'b0, 1'b1, 11'h7FF,          11'h7FF,          11'h7FF,          11'b1110_0000001);
      vecs[4] = mk(16'hABCD, 1'b0, 1'b0, 11'b0111_0001000, 11'b1011_1100000, 11'b1101_0110001, 11'b1110_1000010);
      vecs[5] = mk(16'h5678, 1'b0, 1'b0, 11'b0111_0100100, 11'b1011_0100000, 11'b1101_0001111, 11'b1110_0000000);
      vecs[6] = mk(16'h00F0, 1'b1, 1'b1, 11'h7FF,          11'h7FF,          11'b1011_0111000, 11'b0111_0000001);
      vecs[7] = mk(16'h8E07, 1'b0, 1'b1, 11'b0111_0000000, 11'b1011_0110000, 11'b1101_0000001, 11'b1110_0001111);
      vecs[8] = mk(16'h0000, 1'b0, 1'b0, 11'b0111_0000001, 11'b1011_0000001, 11'b1101_0000001, 11'b1110_0000001);
      vecs[9] = mk(16'h0905, 1'b1, 1'b1, 11'h7FF,          11'b1101_0000100, 11'b1011_0000001, 11'b0111_0100100);

      // ---------------- reset state ----------------
      RST_N  = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_display", 16'(display_out), 16'h07FF);
      chk("rst_ready",   16'(load_ready),  16'd1);
      chk("rst_fd",      16'(frame_done),  16'd0);
      RST_N = 1'b1;

      // ---------------- table-driven frames ----------------
      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // ---------------- double buffer / no tear ----------------
      run_vec(vecs[0], 10);               // now at a boundary showing 1234
      push_frame(vecs[0]);
      for (int i = 0; i < 5; i++) sb_step("db_old", 1'b0);
      load_valid = 1'b1;                  // in slot 1
      load_data  = vecs[4].value;
      push_frame(vecs[4]);
      sb_step("db_old", 1'b0);
      load_data = vecs[5].value;          // held valid with the next value
      chk("db_ready_blocked", 16'(load_ready), 16'd0);
      for (int i = 0; i < 10; i++) begin
         sb_step("db_old_tail", (i == 9));
         chk("db_ready", 16'(load_ready), (i == 9) ? 16'd1 : 16'd0);
      end
      push_frame(vecs[5]);
      sb_step("db_new", 1'b0);
      chk("db_second_accepted", 16'(load_ready), 16'd0);
      load_valid = 1'b0;
      for (int i = 0; i < 15; i++) sb_step("db_new", (i == 14));
      chk("db_second_commit", 16'(load_ready), 16'd1);
      for (int i = 0; i < 16; i++) sb_step("db_5678", (i == 15));

      // ---------------- enable drop mid-frame with pending load ----------------
      push_word(vecs[5].exp[0], 4);
      push_word(vecs[5].exp[1], 4);
      push_word(vecs[5].exp[2], 1);
      for (int i = 0; i < 5; i++) sb_step("en_pre", 1'b0);
      load_valid = 1'b1;
      load_data  = vecs[4].value;
      sb_step("en_pre", 1'b0);
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) sb_step("en_pre", 1'b0);
      chk("en_pending", 16'(load_ready), 16'd0);
      enable = 1'b0;                      // during slot 2
      push_word(11'h7FF, 2);
      sb_step("en_dark", 1'b0);
      sb_step("en_dark", 1'b0);
      chk("en_dark_commit", 16'(load_ready), 16'd1);
      enable = 1'b1;
      push_frame(vecs[4]);
      for (int i = 0; i < 16; i++) sb_step("en_resume", (i == 15));

      // ---------------- async reset mid-frame ----------------
      load_valid = 1'b1;
      load_data  = vecs[5].value;
      push_word(vecs[4].exp[0], 1);
      sb_step("ar_pre", 1'b0);
      load_valid = 1'b0;
      chk("ar_pending", 16'(load_ready), 16'd0);
      #2;
      RST_N = 1'b0;
      #1;                                 // before the next rising edge
      chk("ar_display", 16'(display_out), 16'h07FF);
      chk("ar_ready",   16'(load_ready),  16'd1);
      chk("ar_fd",      16'(frame_done),  16'd0);
      @(negedge CLK);
      chk("ar_hold", 16'(display_out), 16'h07FF);
      RST_N = 1'b1;
      push_word(vecs[8].exp[0], 1);       // active cleared to 0, scan restarts at slot 0
      sb_step("ar_after", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
